imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time writer for the instruction memory read by the fetch stage. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into the instruction memory write port. The pipeline is held in reset (core_hold) until a complete, valid image has landed. Sits between the host/UART byte source and ins_mem; the core only fetches after done.

Parameters:
ADDR_W, 10, instruction memory word-address width (capacity 2^ADDR_W words)
BASE_WORD, 0, word address of the first written instruction

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
in_valid  input  1  byte source has a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle (transfer = in_valid & in_ready)
load_req  input  1  pulse: restart a load from DONE or ERROR
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  word to write
core_hold  output  1  holds the pipeline in reset while high
done  output  1  image loaded successfully (level)
err  output  1  framing/length/checksum failure (level)
err_code  output  2  0 none, 1 length overflow, 2 checksum mismatch

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, LE), then N×4 payload bytes (each word LE, byte0 = bits[7:0]). With LOADER_CSUM_EN, one trailing checksum byte follows the payload.
- FSM states: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR. Reset state is LEN_LO.
- Reset values: in_ready 0 in the reset cycle (in_ready is registered/decoded from state, so it is 1 on the first clock after reset release), imem_we 0, imem_addr 0, imem_wdata 0, core_hold 1, done 0, err 0, err_code 0. Internal counters are 0. Assertion of RESET mid-load aborts immediately; no further writes occur.
- in_ready = 1 in LEN_LO, LEN_HI, DATA, and CSUM; 0 in DONE and ERROR. The loader never stalls the source inside a frame.
- LEN_LO --xfer--> LEN_HI. On the LEN_HI transfer:
  - N > 2^ADDR_W - BASE_WORD -> ERROR, err_code 1.
  - N == 0 -> CSUM (feature on) or DONE (feature off).
  - Otherwise -> DATA.
- DATA: a 2-bit byte counter shifts bytes into the word assembler.
  - On the 4th byte transfer the word is registered. In the next cycle imem_we=1, imem_addr=BASE_WORD+word_idx, imem_wdata=word. word_idx then increments (latency 1 cycle from last byte to write).
  - After the write of word N-1: -> CSUM (feature on) or DONE (feature off).
  - Bytes arriving back-to-back during a write cycle are accepted; the assembler is independent of the write register.
- DONE: core_hold=0, done=1. Extra in_valid bytes are ignored.
- ERROR: core_hold=1, err=1. Memory contents are undefined.
- load_req in DONE or ERROR: next cycle -> LEN_LO, with core_hold=1, done=0, err=0, err_code=0, and counters cleared. load_req in any other state is ignored.
- imem_addr arithmetic is modulo 2^ADDR_W. The length check guarantees no wrap occurs.

Optional Feature:
LOADER_CSUM_EN
- Defined: the loader keeps a running XOR of all payload bytes (length bytes excluded). In CSUM, one byte is accepted. Match -> DONE. Mismatch -> ERROR with err_code 2. Words are already written even on mismatch, but core_hold stays 1.
- Undefined: the CSUM state and XOR register are absent. The last word write goes directly to DONE, and err_code 2 never occurs.

Decomposition:
- Shared package imem_loader_pkg holds:
  - The state enum.
  - The err_code constants ERR_NONE, ERR_LEN, ERR_CSUM.
  - The frame constant LEN_BYTES=2.
- One natural sub-module, word_assembler: byte counter plus LE shift register, with outputs word and word_valid.

Test Plan:
- N=2, bytes 02 00 | 13 00 50 00 | 93 00 A0 00 (feature off) -> writes 0x00500013 at addr 0 and 0x00A00093 at addr 1, each imem_we pulsed exactly once. done=1 and core_hold=0 one cycle after the second write.
- in_valid toggling randomly (50%) over the same frame -> identical writes; no byte is lost or duplicated.
- ADDR_W=4, BASE_WORD=0, length 0x0011 -> ERROR, err_code=1, no imem_we. load_req, then a valid N=1 frame -> done=1.
- LOADER_CSUM_EN, N=1, payload 13 00 50 00, csum 0x43 -> DONE. Same frame with csum 0x42 -> err=1, err_code=2, core_hold=1.
- N=0 -> DONE (feature off) or DONE after the csum byte 0x00 (feature on), with no write.
- RESET low after 2 of 4 words -> all outputs at reset values asynchronously. The next full frame loads from addr BASE_WORD.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding, error codes and frame constants
// for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    localparam int LEN_BYTES = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects four stream bytes little-endian and presents the
// finished word with a one-cycle word_valid strobe the cycle after byte 3.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        last_byte;

    always_comb begin
        last_byte = en && cnt_q == 2'd3;
        cnt_d     = clr ? 2'd0 : en ? cnt_q + 2'd1 : cnt_q;
        shift_d   = clr ? 24'd0 : en ? {byte_in, shift_q[23:8]} : shift_q;
        word_d    = clr ? 32'd0 : last_byte ? {byte_in, shift_q} : word_q;
        valid_d   = !clr && last_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> instruction memory writes, holding the core
// until a full image lands. Define LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_WORD = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int          LEN_W = 8 * LEN_BYTES;
    localparam int          IDX_W = ADDR_W + 1;
    localparam int unsigned CAP   = (32'd1 << ADDR_W) - BASE_WORD;
`ifdef LOADER_CSUM_EN
    localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
    localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               xfer, asm_en, clr, last_write;
`ifdef LOADER_CSUM_EN
    logic [7:0]         csum_q, csum_d;
    logic               csum_ok;
`endif

    assign xfer = in_valid && in_ready_q;
    assign clr  = load_req && (state_q == ST_DONE || state_q == ST_ERROR);

    word_assembler u_asm (
        .clk        (CLK),
        .rst_n      (RESET),
        .clr        (clr),
        .en         (asm_en),
        .byte_in    (in_data),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

    always_comb begin
        last_write = imem_we && (LEN_W'(idx_q) + LEN_W'(1) == len_q);
        // a byte landing during the final write belongs to the trailer, not the payload
        asm_en     = xfer && state_q == ST_DATA && !last_write;
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        idx_d      = idx_q + IDX_W'(imem_we);
        err_code_d = err_code_q;
`ifdef LOADER_CSUM_EN
        csum_d     = csum_q ^ (asm_en ? in_data : 8'h00);
        csum_ok    = in_data == csum_q;
`endif
        case (state_q)
            ST_LEN_LO: if (xfer) begin
                len_lo_d = in_data;
                state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: if (xfer) begin
                len_d = {in_data, len_lo_q};
                if (32'(len_d) > CAP) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_LEN;
                end else begin
                    state_d = (len_d == '0) ? ST_AFTER_DATA : ST_DATA;
                end
            end
            ST_DATA: if (last_write) begin
                state_d = ST_AFTER_DATA;
`ifdef LOADER_CSUM_EN
                if (xfer) begin
                    state_d    = csum_ok ? ST_DONE : ST_ERROR;
                    err_code_d = csum_ok ? ERR_NONE : ERR_CSUM;
                end
`endif
            end
`ifdef LOADER_CSUM_EN
            ST_CSUM: if (xfer) begin
                state_d    = csum_ok ? ST_DONE : ST_ERROR;
                err_code_d = csum_ok ? ERR_NONE : ERR_CSUM;
            end
`endif
            ST_DONE, ST_ERROR: if (load_req) begin
                state_d    = ST_LEN_LO;
                len_lo_d   = 8'd0;
                len_d      = '0;
                idx_d      = '0;
                err_code_d = ERR_NONE;
`ifdef LOADER_CSUM_EN
                csum_d     = 8'h00;
`endif
            end
            default: state_d = ST_LEN_LO;
        endcase
        in_ready_d = state_d inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_LEN_LO;
            in_ready_q <= 1'b0;
            len_lo_q   <= 8'd0;
            len_q      <= '0;
            idx_q      <= '0;
            err_code_q <= ERR_NONE;
`ifdef LOADER_CSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            err_code_q <= err_code_d;
`ifdef LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign imem_addr = imem_we ? ADDR_W'(BASE_WORD) + idx_q[ADDR_W-1:0] : '0;
    assign core_hold = state_q != ST_DONE;
    assign done      = state_q == ST_DONE;
    assign err       = state_q == ST_ERROR;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the boot loader with a 16-word memory
// (ADDR_W=4, BASE_WORD=0); checksum steps follow LOADER_CSUM_EN.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        load_req = 1'b0;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold, done, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    logic [3:0]  wa[$];
    logic [31:0] wd[$];

    imem_loader #(.ADDR_W(4), .BASE_WORD(0)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int  n;
        bit  acc;
        if (gap) repeat ($urandom_range(0, 1)) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
    endtask

    task automatic end_frame(input logic [7:0] csum);
`ifdef LOADER_CSUM_EN
        send(csum, 1'b0);
`else
        tick();
`endif
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic frame2(input bit gap);
        send(8'h02, gap);
        send(8'h00, gap);
        send_word(32'h0050_0013, gap);
        send_word(32'h00A0_0093, gap);
    endtask

    task automatic check_frame2(input string tag);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd1);
        check({tag, "_addr"}, {28'd0, imem_addr}, 32'd1);
        check({tag, "_wdata"}, imem_wdata, 32'h00A0_0093);
        check({tag, "_notdone"}, {31'd0, done}, 32'd0);
        end_frame(8'h70);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_hold"}, {31'd0, core_hold}, 32'd0);
        check({tag, "_nwr"}, wa.size(), 32'd2);
        check({tag, "_a0"}, {28'd0, wa[0]}, 32'd0);
        check({tag, "_d0"}, wd[0], 32'h0050_0013);
        check({tag, "_a1"}, {28'd0, wa[1]}, 32'd1);
        check({tag, "_d1"}, wd[1], 32'h00A0_0093);
    endtask

    initial begin
        // reset state
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {28'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        check("rel_ready", {31'd0, in_ready}, 32'd1);

        // N=2 back-to-back
        frame2(1'b0);
        check_frame2("f2");
        check("done_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        tick();
        in_valid = 1'b0;
        check("done_ignore_nwr", wa.size(), 32'd2);
        check("done_stays", {31'd0, done}, 32'd1);

        // same frame with random source gaps
        pulse_load();
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_hold", {31'd0, core_hold}, 32'd1);
        check("reload_ready", {31'd0, in_ready}, 32'd1);
        wa.delete();
        wd.delete();
        frame2(1'b1);
        check_frame2("gap");

        // length overflow: 17 words into a 16-word memory
        pulse_load();
        wa.delete();
        wd.delete();
        send(8'h11, 1'b0);
        send(8'h00, 1'b0);
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_code", {30'd0, err_code}, 32'd1);
        check("ovf_hold", {31'd0, core_hold}, 32'd1);
        check("ovf_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check("ovf_nwr", wa.size(), 32'd0);

        // recovery with N=1
        pulse_load();
        check("rec_err", {31'd0, err}, 32'd0);
        check("rec_code", {30'd0, err_code}, 32'd0);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h0050_0013, 1'b0);
        end_frame(8'h43);
        check("n1_done", {31'd0, done}, 32'd1);
        check("n1_nwr", wa.size(), 32'd1);
        check("n1_d0", wd[0], 32'h0050_0013);

        // full memory: N=16 is the largest legal length
        pulse_load();
        wa.delete();
        wd.delete();
        send(8'h10, 1'b0);
        send(8'h00, 1'b0);
        check("n16_noerr", {31'd0, err}, 32'd0);
        for (int i = 0; i < 16; i++) send_word({4{i[7:0]}}, 1'b0);
        check("n16_last_addr", {28'd0, imem_addr}, 32'd15);
        end_frame(8'h00);
        check("n16_done", {31'd0, done}, 32'd1);
        check("n16_nwr", wa.size(), 32'd16);
        check("n16_a15", {28'd0, wa[15]}, 32'd15);
        check("n16_d15", wd[15], 32'h0F0F_0F0F);
        check("n16_d7", wd[7], 32'h0707_0707);

`ifdef LOADER_CSUM_EN
        // checksum mismatch
        pulse_load();
        wa.delete();
        wd.delete();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h0050_0013, 1'b0);
        send(8'h42, 1'b0);
        check("csum_err", {31'd0, err}, 32'd1);
        check("csum_code", {30'd0, err_code}, 32'd2);
        check("csum_hold", {31'd0, core_hold}, 32'd1);
        check("csum_nwr", wa.size(), 32'd1);
`endif

        // N=0: no writes
        pulse_load();
        wa.delete();
        wd.delete();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
`ifdef LOADER_CSUM_EN
        send(8'h00, 1'b0);
`endif
        check("n0_done", {31'd0, done}, 32'd1);
        tick();
        check("n0_nwr", wa.size(), 32'd0);

        // async reset after 2 of 4 words, during the second write
        pulse_load();
        wa.delete();
        wd.delete();
        send(8'h04, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h4433_2211, 1'b0);
        send_word(32'h8877_6655, 1'b0);
        check("mid_we_before", {31'd0, imem_we}, 32'd1);
        RESET = 1'b0;
        #1;
        check("mid_we", {31'd0, imem_we}, 32'd0);
        check("mid_addr", {28'd0, imem_addr}, 32'd0);
        check("mid_wdata", imem_wdata, 32'd0);
        check("mid_ready", {31'd0, in_ready}, 32'd0);
        check("mid_hold", {31'd0, core_hold}, 32'd1);
        check("mid_nwr", wa.size(), 32'd1);
        tick();
        RESET = 1'b1;
        wa.delete();
        wd.delete();
        frame2(1'b0);
        check_frame2("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
